// File: rtl/ranc_noc_pkg.sv
// Shared NoC definitions: source-index encoding and default packet/FIFO sizes
// used by both the path decoders and the path mergers.
package ranc_noc_pkg;

  localparam int DATA_WIDTH_DEFAULT = 32;
  localparam int FIFO_DEPTH_DEFAULT = 4;

  typedef logic [1:0] src_t;

  localparam src_t SRC_A = 2'd0;
  localparam src_t SRC_B = 2'd1;
  localparam src_t SRC_C = 2'd2;

  // Round-robin successor: A -> B -> C -> A.
  function automatic src_t next_src(input src_t s);
    return (s == SRC_C) ? SRC_A : src_t'(s + 2'd1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a combinational (non-registered) head.
// full/empty come straight from the registered count, so a push in the same
// cycle as a pop on a full FIFO is still refused.
module sync_fifo
  import ranc_noc_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  wen,
  input  logic                  ren,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty,
  output logic                  full
);

  localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  push;
  logic                  pop;

  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);
  assign push  = wen & ~full;
  assign pop   = ren & ~empty;
  assign dout  = mem[rptr];

  // Storage array: written on an accepted push, never reset.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/path_merger_3way.sv
// Three-input path merger: each source is buffered in a sync_fifo and a
// round-robin arbiter drains them into one registered output stream.
//
// Handshake: a source may assert wen_x only while full_x is low; the packet is
// taken at that rising edge. Downstream, wen_out is a one-cycle valid pulse
// that is never raised for a cycle in which full_out was sampled high.
module path_merger_3way
  import ranc_noc_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din_a,
  input  logic                  wen_a,
  output logic                  full_a,
  input  logic [DATA_WIDTH-1:0] din_b,
  input  logic                  wen_b,
  output logic                  full_b,
  input  logic [DATA_WIDTH-1:0] din_c,
  input  logic                  wen_c,
  output logic                  full_c,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  wen_out,
  input  logic                  full_out
);

  logic [DATA_WIDTH-1:0] head_a, head_b, head_c, head;
  logic [2:0]            fifo_empty;
  logic [2:0]            ren;
  src_t                  last_grant;
  src_t                  grant_src;
  src_t                  cand;
  logic                  grant_valid;

  sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo_a (
    .clk(clk), .rst(rst), .din(din_a), .wen(wen_a), .ren(ren[SRC_A]),
    .dout(head_a), .empty(fifo_empty[SRC_A]), .full(full_a)
  );

  sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo_b (
    .clk(clk), .rst(rst), .din(din_b), .wen(wen_b), .ren(ren[SRC_B]),
    .dout(head_b), .empty(fifo_empty[SRC_B]), .full(full_b)
  );

  sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo_c (
    .clk(clk), .rst(rst), .din(din_c), .wen(wen_c), .ren(ren[SRC_C]),
    .dout(head_c), .empty(fifo_empty[SRC_C]), .full(full_c)
  );

  // Round-robin search starting after last_grant; blocked by downstream full.
  always_comb begin
    grant_valid = 1'b0;
    grant_src   = last_grant;
    cand        = last_grant;
    for (int i = 0; i < 3; i++) begin
      cand = next_src(cand);
      if (!full_out && !grant_valid && !fifo_empty[cand]) begin
        grant_valid = 1'b1;
        grant_src   = cand;
      end
    end
  end

  // Pop strobe to the granted FIFO and selection of its head.
  always_comb begin
    ren    = 3'b000;
    head   = head_c;
    if (grant_valid) ren[grant_src] = 1'b1;
    case (grant_src)
      SRC_A:   head = head_a;
      SRC_B:   head = head_b;
      default: head = head_c;
    endcase
  end

  // Output register and round-robin pointer; C after reset gives A first turn.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      wen_out    <= 1'b0;
      last_grant <= SRC_C;
    end else begin
      wen_out <= grant_valid;
      if (grant_valid) begin
        dout       <= head;
        last_grant <= grant_src;
      end
    end
  end

endmodule
